// File: rtl/byte_joining_param.sv
// Lane-to-stream byte joiner: serialises the active lanes of each accepted word
// onto one WIDTH-bit output, lane 0 first, through a two-entry word buffer.
module byte_joining_param #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int MW    = 2,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] lane_data,
  input  logic [MW-1:0]          lane_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  output logic [LW-1:0]          out_lane,
  output logic                   out_first
);

  localparam int LOG2_LANES = $clog2(LANES);

  typedef logic [LANES-1:0][WIDTH-1:0] word_t;

  // Each word is stored with the index of its last active lane, not the
  // count, so the finish test is a plain compare against the lane index.
  function automatic logic [LW-1:0] last_lane(input logic [MW-1:0] mode);
    if (int'(mode) >= LOG2_LANES) return LW'(LANES - 1);
    return LW'((1 << mode) - 1);
  endfunction

  // Buffer entries: CUR is the word being drained, NXT the parked word.
  logic            cur_valid, cur_valid_d;
  word_t           cur_data,  cur_data_d;
  logic [LW-1:0]   cur_last,  cur_last_d;
  logic [LW-1:0]   cur_idx,   cur_idx_d;
  logic            nxt_valid, nxt_valid_d;
  word_t           nxt_data,  nxt_data_d;
  logic [LW-1:0]   nxt_last,  nxt_last_d;

  logic [WIDTH-1:0] out_d;
  logic             out_valid_d;
  logic [LW-1:0]    out_lane_d;
  logic             out_first_d;

  logic          accept;
  logic          cur_finish;
  logic [LW-1:0] in_last;

  // Depends only on registered state and reset, never on in_valid.
  assign in_ready   = !nxt_valid && !reset;
  assign accept     = in_valid && in_ready;
  assign cur_finish = cur_valid && (cur_idx == cur_last);
  assign in_last    = last_lane(lane_mode);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    cur_valid_d = cur_valid;
    cur_data_d  = cur_data;
    cur_last_d  = cur_last;
    cur_idx_d   = cur_idx;
    nxt_valid_d = nxt_valid;
    nxt_data_d  = nxt_data;
    nxt_last_d  = nxt_last;

    if (!cur_valid || cur_finish) begin
      // CUR is free at this edge: refill from NXT first, else straight from input.
      cur_idx_d = '0;
      if (nxt_valid) begin
        cur_valid_d = 1'b1;
        cur_data_d  = nxt_data;
        cur_last_d  = nxt_last;
        nxt_valid_d = 1'b0;
      end else if (accept) begin
        cur_valid_d = 1'b1;
        cur_data_d  = lane_data;
        cur_last_d  = in_last;
      end else begin
        cur_valid_d = 1'b0;
      end
    end else begin
      cur_idx_d = cur_idx + 1'b1;
      if (accept) begin
        nxt_valid_d = 1'b1;
        nxt_data_d  = lane_data;
        nxt_last_d  = in_last;
      end
    end
  end

  always_comb begin
    out_d       = '0;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_lane_d  = out_lane;
    if (cur_valid) begin
      out_d       = cur_data[cur_idx];
      out_valid_d = 1'b1;
      out_first_d = (cur_idx == '0);
      out_lane_d  = cur_idx;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_valid <= 1'b0;
      nxt_valid <= 1'b0;
      cur_idx   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_first <= 1'b0;
    end else begin
      cur_valid <= cur_valid_d;
      nxt_valid <= nxt_valid_d;
      cur_idx   <= cur_idx_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      out_lane  <= out_lane_d;
      out_first <= out_first_d;
    end
  end

  // NOTE: payload storage is left without reset; it is only ever read while
  // the matching valid flag, which is reset, is set.
  always_ff @(posedge clk) begin
    cur_data <= cur_data_d;
    cur_last <= cur_last_d;
    nxt_data <= nxt_data_d;
    nxt_last <= nxt_last_d;
  end

endmodule

// File: tb/tb_byte_joining_param.sv
// Directed self-checking bench for byte_joining_param (LANES=4, WIDTH=8, MW=2).
module tb_byte_joining_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lane_data;
  logic [1:0]  lane_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic [1:0]  out_lane;
  logic        out_first;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] lane;
    logic       first;
  } exp_t;

  logic [31:0] word_q[$];
  logic [1:0]  mode_q[$];
  exp_t        exp_q[$];

  byte_joining_param #(.LANES(4), .WIDTH(8), .MW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .lane_data (lane_data),
    .lane_mode (lane_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_lane  (out_lane),
    .out_first (out_first)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] d, input logic [1:0] lane,
                            input logic first);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out"}, out, d);
    check({tag, " out_lane"}, out_lane, lane);
    check({tag, " out_first"}, out_first, first);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [1:0] lane, input logic first);
    exp_t e;
    e.d = d; e.lane = lane; e.first = first;
    return e;
  endfunction

  // Presents queued words with the handshake and expects the queued bytes on
  // consecutive cycles starting one edge after the first accept.
  task automatic run_stream(input string tag, input bit chk_rdy);
    bit   armed  = 0;
    bit   acc;
    int   budget = 0;
    exp_t e;
    while ((word_q.size() > 0 || exp_q.size() > 0) && budget < 100) begin
      if (word_q.size() > 0) begin
        in_valid  = 1'b1;
        lane_data = word_q[0];
        lane_mode = mode_q[0];
        if (chk_rdy) check({tag, " in_ready"}, in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      step();
      budget++;
      if (acc) begin
        void'(word_q.pop_front());
        void'(mode_q.pop_front());
      end
      if (armed && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_byte(tag, e.d, e.lane, e.first);
      end
      if (acc) armed = 1;
    end
    in_valid = 1'b0;
    check({tag, " completed in budget"}, (word_q.size() == 0 && exp_q.size() == 0), 1);
    word_q.delete(); mode_q.delete(); exp_q.delete();
    step();
    check({tag, " drained out_valid"}, out_valid, 0);
  endtask

  logic [1:0] rdy_pat [13] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    int   wi;
    bit   acc;
    int   b;
    logic [31:0] w;

    // Reset held with traffic present.
    reset = 1'b1; in_valid = 1'b1; lane_mode = 2'd2; lane_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      lane_data = $urandom;
      step();
      check("reset in_ready", in_ready, 0);
      check("reset out", out, 0);
      check("reset out_valid", out_valid, 0);
      check("reset out_first", out_first, 0);
      check("reset out_lane", out_lane, 0);
    end
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("post-reset out", out, 0);
    check("post-reset out_valid", out_valid, 0);
    check("post-reset out_first", out_first, 0);
    check("post-reset in_ready", in_ready, 1);

    // x4 single word, latency and trailing drop of out_valid.
    lane_data = 32'hD3C2B1A0; lane_mode = 2'd2; in_valid = 1'b1;
    check("x4 in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("x4 accept edge out_valid", out_valid, 0);
    step(); check_byte("x4 lane0", 8'hA0, 2'd0, 1'b1);
    step(); check_byte("x4 lane1", 8'hB1, 2'd1, 1'b0);
    step(); check_byte("x4 lane2", 8'hC2, 2'd2, 1'b0);
    step(); check_byte("x4 lane3", 8'hD3, 2'd3, 1'b0);
    step();
    check("x4 end out_valid", out_valid, 0);
    check("x4 end out", out, 0);
    check("x4 end out_first", out_first, 0);
    check("x4 end out_lane holds", out_lane, 3);

    // x4 back-to-back: four words, in_ready pattern and 16 gapless bytes.
    wi = 0;
    lane_mode = 2'd2;
    for (int c = 0; c < 18; c++) begin
      in_valid = (wi < 4);
      for (int l = 0; l < 4; l++) w[l*8 +: 8] = 8'((wi + 1) * 16 + l);
      lane_data = w;
      if (c < 13) check($sformatf("b2b in_ready c%0d", c), in_ready, rdy_pat[c]);
      acc = in_valid && in_ready;
      step();
      if (acc) wi++;
      if (c >= 1 && c <= 16) begin
        b = c - 1;
        check_byte($sformatf("b2b byte%0d", b), 8'((b / 4 + 1) * 16 + b % 4),
                   2'(b % 4), (b % 4) == 0);
      end
      if (c == 17) check("b2b end out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    // x1 streaming: one byte per word, in_ready never drops.
    for (int i = 0; i < 8; i++) begin
      word_q.push_back({8'hEE, 8'hEE, 8'hEE, 8'(i + 1)});
      mode_q.push_back(2'd0);
      exp_q.push_back(mk(8'(i + 1), 2'd0, 1'b1));
    end
    run_stream("x1", 1'b1);

    // Mode change with clamp: x2, mode 3 (clamped to x4), x1.
    word_q.push_back(32'hEEEE2211); mode_q.push_back(2'd1);
    word_q.push_back(32'h44332211); mode_q.push_back(2'd3);
    word_q.push_back(32'hEEEEEE55); mode_q.push_back(2'd0);
    exp_q.push_back(mk(8'h11, 2'd0, 1'b1));
    exp_q.push_back(mk(8'h22, 2'd1, 1'b0));
    exp_q.push_back(mk(8'h11, 2'd0, 1'b1));
    exp_q.push_back(mk(8'h22, 2'd1, 1'b0));
    exp_q.push_back(mk(8'h33, 2'd2, 1'b0));
    exp_q.push_back(mk(8'h44, 2'd3, 1'b0));
    exp_q.push_back(mk(8'h55, 2'd0, 1'b1));
    run_stream("modechg", 1'b0);

    // Reset in the middle of a word discards the remainder.
    lane_data = 32'hD3C2B1A0; lane_mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); check_byte("mid lane0", 8'hA0, 2'd0, 1'b1);
    step(); check_byte("mid lane1", 8'hB1, 2'd1, 1'b0);
    reset = 1'b1;
    step();
    check("mid reset out_valid", out_valid, 0);
    check("mid reset out", out, 0);
    check("mid reset in_ready", in_ready, 0);
    reset = 1'b0;
    step();
    check("mid release out_valid", out_valid, 0);
    check("mid release out", out, 0);
    word_q.push_back(32'h78563412); mode_q.push_back(2'd2);
    exp_q.push_back(mk(8'h12, 2'd0, 1'b1));
    exp_q.push_back(mk(8'h34, 2'd1, 1'b0));
    exp_q.push_back(mk(8'h56, 2'd2, 1'b0));
    exp_q.push_back(mk(8'h78, 2'd3, 1'b0));
    run_stream("after reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
